udp_pkt_reader: RTL and testbench

Read-side controller for the ping-pong UDP packet buffer. On every main-sync falling edge the just-completed buffer bank becomes readable; this block then sequences read addresses 0..PKT_WORDS-1 through the buffer's read port. It absorbs the RAM read latency in a small prefetch FIFO and streams the words to the UDP transmit path over a valid/ready interface with start/end-of-packet markers. It also detects frame overruns, where a new sync arrives before the packet has drained.

---
 rtl/udp_pkt_reader.sv | 193 +++++++++++++++++++
 tb/tb_udp_pkt_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_pkt_reader.sv
`default_nettype none
// udp_pkt_reader: after each main-sync falling edge, reads the completed buffer bank
// and streams it out through a fall-through prefetch FIFO with sop/eop/err markers.
module udp_pkt_reader #(
  parameter int PKT_WORDS  = 527,
  parameter int RD_LAT     = 2,
  parameter int START_DLY  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_msync_n,
  input  logic        i_enable,
  output logic [9:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic [31:0] o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_tx_sop,
  output logic        o_tx_eop,
  output logic        o_tx_err,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_overrun_cnt
);

  localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW        = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
  localparam logic [7:0]  DLY_LOAD  = 8'(START_DLY - 1);
  localparam logic [10:0] PKT_LEN   = 11'(PKT_WORDS);
  localparam logic [9:0]  LAST_BEAT = 10'(PKT_WORDS - 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_ABORT} state_t;

  state_t              state, state_nxt;
  logic                prev_n;
  logic                sp;
  logic [7:0]          dly_cnt;
  logic [10:0]         addr;
  logic [9:0]          beat;
  logic [RD_LAT-1:0]   vsr;
  logic [RD_LAT:0]     vsr_in;
  logic [31:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       occ, in_flight, pending;
  logic                arrive, fifo_valid, send_valid;
  logic [31:0]         head;
  logic                pop, xfer, issue, wr, rd, eop_xfer;
  logic                load_dly, start_send, flush, frame_inc, overrun_inc;
  logic                busy;
  logic [15:0]         frame_cnt, overrun_cnt;

  assign sp = prev_n & ~i_msync_n;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CW'(vsr[i]);
  end

  // Fall-through: a word returning from the RAM is presentable in the cycle it arrives.
  assign arrive     = vsr[RD_LAT-1];
  assign fifo_valid = (occ != '0) || arrive;
  assign head       = (occ != '0) ? mem[rd_ptr] : i_rd_data;
  assign send_valid = (state == S_SEND) && fifo_valid;
  assign pop        = send_valid && i_tx_ready;
  assign xfer       = o_tx_valid && i_tx_ready;
  assign eop_xfer   = pop && (beat == LAST_BEAT);
  assign pending    = in_flight + occ - CW'(pop);
  assign issue      = (state == S_SEND) && (addr < PKT_LEN) && (pending < CW'(FIFO_DEPTH));
  assign wr         = arrive && !(pop && (occ == '0)) && !flush;
  assign rd         = pop && (occ != '0);
  assign vsr_in     = {vsr, issue};

  assign o_tx_valid    = send_valid || (state == S_ABORT);
  assign o_tx_data     = send_valid ? head : 32'd0;
  assign o_tx_sop      = send_valid && (beat == 10'd0);
  assign o_tx_eop      = (send_valid && (beat == LAST_BEAT)) || (state == S_ABORT);
  assign o_tx_err      = (state == S_ABORT);
  assign o_rd_addr     = addr[9:0];
  assign o_busy        = busy;
  assign o_frame_cnt   = frame_cnt;
  assign o_overrun_cnt = overrun_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_dly    = 1'b0;
    start_send  = 1'b0;
    flush       = 1'b0;
    frame_inc   = 1'b0;
    overrun_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (sp && i_enable) begin
          state_nxt = S_WAIT;
          load_dly  = 1'b1;
        end
      end
      S_WAIT: begin
        if (sp) begin
          load_dly    = 1'b1;
          overrun_inc = 1'b1;
        end else if (dly_cnt == 8'd0) begin
          state_nxt  = S_SEND;
          start_send = 1'b1;
        end
      end
      S_SEND: begin
        if (eop_xfer) begin
          frame_inc = 1'b1;
          if (sp && i_enable) begin
            state_nxt = S_WAIT;
            load_dly  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (sp) begin
          overrun_inc = 1'b1;
          flush       = 1'b1;
          // A beat accepted in this very cycle already reached the sink.
          if ((beat != 10'd0) || xfer) begin
            state_nxt = S_ABORT;
          end else begin
            state_nxt = S_WAIT;
            load_dly  = 1'b1;
          end
        end
      end
      S_ABORT: begin
        overrun_inc = sp;
        if (xfer) begin
          state_nxt = S_WAIT;
          load_dly  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_n      <= 1'b1;
      dly_cnt     <= 8'd0;
      addr        <= 11'd0;
      beat        <= 10'd0;
      vsr         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      busy        <= 1'b0;
      frame_cnt   <= 16'd0;
      overrun_cnt <= 16'd0;
    end else begin
      prev_n <= i_msync_n;
      busy   <= (state_nxt != S_IDLE);

      if (load_dly)                             dly_cnt <= DLY_LOAD;
      else if (state == S_WAIT && dly_cnt != 0) dly_cnt <= dly_cnt - 8'd1;

      if (start_send) addr <= 11'd0;
      else if (issue) addr <= addr + 11'd1;

      if (start_send) beat <= 10'd0;
      else if (pop)   beat <= beat + 10'd1;

      if (flush) begin
        vsr    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        vsr <= vsr_in[RD_LAT-1:0];
        if (wr) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
        if (rd) rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
        occ <= occ + CW'(wr) - CW'(rd);
      end

      if (frame_inc)   frame_cnt   <= frame_cnt + 16'd1;
      if (overrun_inc) overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= i_rd_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_pkt_reader.sv
`default_nettype none
// tb_udp_pkt_reader: scoreboard bench with a RAM model returning data = address.
module tb_udp_pkt_reader;

  localparam int PKT_WORDS = 527;
  localparam int RD_LAT    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_msync_n;
  logic        i_enable;
  logic [9:0]  o_rd_addr;
  logic [31:0] i_rd_data;
  logic [31:0] o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_tx_sop, o_tx_eop, o_tx_err, o_busy;
  logic [15:0] o_frame_cnt, o_overrun_cnt;

  udp_pkt_reader #(
    .PKT_WORDS(PKT_WORDS), .RD_LAT(RD_LAT), .START_DLY(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_msync_n(i_msync_n), .i_enable(i_enable),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_tx_sop(o_tx_sop),
    .o_tx_eop(o_tx_eop), .o_tx_err(o_tx_err), .o_busy(o_busy),
    .o_frame_cnt(o_frame_cnt), .o_overrun_cnt(o_overrun_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: data for the address presented in cycle c appears in cycle c+RD_LAT.
  logic [9:0] ram_pipe [RD_LAT];
  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) ram_pipe[i] <= ram_pipe[i-1];
    ram_pipe[0] <= o_rd_addr;
  end
  assign i_rd_data = {22'd0, ram_pipe[RD_LAT-1]};

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        err;
  } beat_t;

  beat_t       exp_q [$];
  int          n_vec = 0, n_bad = 0;
  int          beats_seen = 0, pkt_beats = 0, max_out = 0, out_now, lat;
  longint      cyc = 0, sop_cyc = 0, eop_cyc = 0;
  logic        in_pkt = 1'b0, hold = 1'b0, last_msync = 1'b1, sp_tb;
  logic [35:0] hold_val;
  beat_t       e;
  logic        bp_mode = 1'b0;
  logic [3:0]  bp_pat = 4'b1001;
  int          bp_idx = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt();
    for (int i = 0; i < PKT_WORDS; i++)
      exp_q.push_back('{data: 32'(i), sop: (i == 0), eop: (i == PKT_WORDS - 1), err: 1'b0});
  endtask

  task automatic push_abort();
    exp_q.push_back('{data: 32'd0, sop: 1'b0, eop: 1'b1, err: 1'b1});
  endtask

  task automatic sync_pulse();
    @(posedge clk); #1; i_msync_n = 1'b0;
    @(posedge clk); #1; i_msync_n = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); #1; k++;
    end
    chk({"drain_", tag}, 64'(exp_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (beats_seen < n && k < budget) begin
      @(posedge clk); #1; k++;
    end
    chk("reach_beats", 64'(beats_seen >= n), 1);
  endtask

  task automatic measure_lat();
    lat = 0;
    while (!o_tx_valid && lat < 20) begin
      @(posedge clk); #1; i_msync_n = 1'b1; lat++;
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (bp_mode) begin
      #1;
      i_tx_ready = bp_pat[bp_idx];
      bp_idx = (bp_idx + 1) % 4;
    end
  end

  always @(negedge clk) begin
    sp_tb = last_msync & ~i_msync_n;
    last_msync = i_msync_n;
    if (rst_n !== 1'b1) begin
      hold   = 1'b0;
      in_pkt = 1'b0;
    end else begin
      if (hold)
        chk("hold_stable", {28'd0, o_tx_valid, o_tx_sop, o_tx_eop, o_tx_err, o_tx_data},
            {28'd0, hold_val});
      if (in_pkt && bp_mode) begin
        out_now = int'(o_rd_addr) - pkt_beats;
        if (out_now > max_out) max_out = out_now;
      end
      if (o_tx_valid && i_tx_ready) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_data", o_tx_data, e.data);
          chk("beat_flags", {o_tx_sop, o_tx_eop, o_tx_err}, {e.sop, e.eop, e.err});
        end
        beats_seen++;
        if (o_tx_sop) begin
          in_pkt    = 1'b1;
          pkt_beats = 0;
          sop_cyc   = cyc;
        end
        pkt_beats++;
        if (o_tx_eop) begin
          in_pkt  = 1'b0;
          eop_cyc = cyc;
        end
      end
      hold     = o_tx_valid && !i_tx_ready && !sp_tb;
      hold_val = {o_tx_valid, o_tx_sop, o_tx_eop, o_tx_err, o_tx_data};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_msync_n = 1'b1; i_enable = 1'b1; i_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_addr", o_rd_addr, 0);
    chk("rst_flags", {o_tx_valid, o_tx_sop, o_tx_eop, o_tx_err, o_busy}, 0);
    chk("rst_data", o_tx_data, 0);
    chk("rst_counters", {o_frame_cnt, o_overrun_cnt}, 0);
    rst_n = 1'b1;

    // Nominal packet
    push_pkt();
    @(posedge clk); #1; i_msync_n = 1'b0;
    lat = 0;
    while (!o_tx_valid && lat < 20) begin
      @(posedge clk); #1; i_msync_n = 1'b1; lat++;
      if (lat == 1) chk("busy_in_wait", o_busy, 1);
    end
    chk("first_valid_lat", lat, 7);
    wait_drain("nominal", 2000);
    chk("nominal_duration", 64'(eop_cyc - sop_cyc), PKT_WORDS - 1);
    chk("nominal_frame_cnt", o_frame_cnt, 1);
    chk("nominal_idle", o_busy, 0);

    // Backpressure with ready pattern 1,0,0,1
    do_reset();
    max_out = 0;
    bp_idx  = 0;
    bp_mode = 1'b1;
    push_pkt();
    sync_pulse();
    wait_drain("backpressure", 5000);
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1; i_tx_ready = 1'b1;
    chk("bp_outstanding_le_depth", 64'(max_out <= 4), 1);
    chk("bp_frame_cnt", o_frame_cnt, 1);

    // Overrun after beat 100: one err beat, then a fresh packet
    do_reset();
    push_pkt();
    beats_seen = 0;
    sync_pulse();
    wait_beats(101, 500);
    i_tx_ready = 1'b0; i_msync_n = 1'b0;
    exp_q.delete();
    push_abort();
    push_pkt();
    @(posedge clk); #1; i_msync_n = 1'b1; i_tx_ready = 1'b1;
    chk("abort_err", o_tx_err, 1);
    chk("abort_overrun_cnt", o_overrun_cnt, 1);
    @(posedge clk); #1;
    chk("abort_frame_cnt_hold", o_frame_cnt, 0);
    wait_drain("overrun_mid", 2000);
    chk("overrun_mid_frame_cnt", o_frame_cnt, 1);

    // Overrun in WAIT (count 2) and one cycle before first valid
    do_reset();
    push_pkt();
    @(posedge clk); #1; i_msync_n = 1'b0;
    @(posedge clk); #1; i_msync_n = 1'b1;
    @(posedge clk); #1; i_msync_n = 1'b0;
    @(posedge clk); #1; i_msync_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("presend_no_valid", o_tx_valid, 0);
    chk("presend_rd_addr", o_rd_addr, 1);
    i_msync_n = 1'b0;
    measure_lat();
    chk("rearm_first_valid_lat", lat, 7);
    chk("early_overrun_cnt", o_overrun_cnt, 2);
    wait_drain("overrun_early", 2000);
    chk("early_frame_cnt", o_frame_cnt, 1);

    // Enable gating at sync, then deassert mid-packet
    do_reset();
    i_enable = 1'b0;
    sync_pulse();
    repeat (8) @(posedge clk);
    #1;
    chk("disabled_busy", o_busy, 0);
    chk("disabled_valid", o_tx_valid, 0);
    i_enable = 1'b1;
    push_pkt();
    beats_seen = 0;
    sync_pulse();
    wait_beats(50, 500);
    i_enable = 1'b0;
    wait_drain("enable_drop", 2000);
    chk("enable_drop_frame_cnt", o_frame_cnt, 1);
    i_enable = 1'b1;

    // Asynchronous reset at beat 300
    do_reset();
    push_pkt();
    beats_seen = 0;
    sync_pulse();
    wait_beats(300, 1000);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_flags", {o_tx_valid, o_tx_sop, o_tx_eop, o_tx_err, o_busy}, 0);
    chk("arst_data_addr", {o_tx_data, 22'd0, o_rd_addr}, 0);
    chk("arst_counters", {o_frame_cnt, o_overrun_cnt}, 0);
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    push_pkt();
    sync_pulse();
    wait_drain("after_reset", 2000);
    chk("after_reset_frame_cnt", o_frame_cnt, 1);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
